// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use hazard controller.
// Cause encoding and the output bundles the priority mux selects between.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_LOADUSE = 2'd1,
    CAUSE_FREEZE  = 2'd2,
    CAUSE_FLUSH   = 2'd3
  } cause_e;

  typedef struct packed {
    logic   pc_write;
    logic   stall;
    logic   noop;
    logic   flush;
    logic   freeze;
    cause_e cause;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    pc_write: 1'b1, stall: 1'b0, noop: 1'b0, flush: 1'b0, freeze: 1'b0,
    cause: CAUSE_NONE
  };

  localparam ctrl_t CTRL_FREEZE = '{
    pc_write: 1'b0, stall: 1'b1, noop: 1'b0, flush: 1'b0, freeze: 1'b1,
    cause: CAUSE_FREEZE
  };

  localparam ctrl_t CTRL_LOADUSE = '{
    pc_write: 1'b0, stall: 1'b1, noop: 1'b1, flush: 1'b0, freeze: 1'b0,
    cause: CAUSE_LOADUSE
  };

  localparam ctrl_t CTRL_FLUSH = '{
    pc_write: 1'b1, stall: 1'b0, noop: 1'b0, flush: 1'b1, freeze: 1'b0,
    cause: CAUSE_FLUSH
  };

  // A source only matters when it is read and is not the hardwired-zero register.
  function automatic logic src_qualified(input logic use_b,
                                         input logic [REG_ADDR_W-1:0] addr);
    return use_b && (addr != {REG_ADDR_W{1'b0}});
  endfunction

endpackage

// File: rtl/load_scoreboard.sv
// Shift register of in-flight loads beyond EX; entry k is the load k+1 stages past EX.
// Produces per-source hits against any valid entry's destination register.
module load_scoreboard
  import hazard_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DEPTH  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              advance_i,
  input  logic              push_valid_i,
  input  logic [ADDR_W-1:0] push_rd_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  input  logic              rs1_use_i,
  input  logic              rs2_use_i,
  output logic              hit1_o,
  output logic              hit2_o
);

  generate
    if (DEPTH == 0) begin : g_none
      logic unused_inputs_s;
      assign unused_inputs_s = ^{clk_i, rst_i, advance_i, push_valid_i, push_rd_i,
                                 rs1_addr_i, rs2_addr_i, rs1_use_i, rs2_use_i};
      assign hit1_o = 1'b0;
      assign hit2_o = 1'b0;
    end else begin : g_sb
      logic [DEPTH-1:0]             valid_q, valid_d;
      logic [DEPTH-1:0][ADDR_W-1:0] rd_q, rd_d;
      logic                         match1_s, match2_s;

      // Shift on advance, hold everything while the pipe is frozen.
      always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        if (advance_i) begin
          valid_d[0] = push_valid_i;
          rd_d[0]    = push_rd_i;
          for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            rd_d[k]    = rd_q[k-1];
          end
        end else begin
          valid_d = valid_q;
          rd_d    = rd_q;
        end
      end

      // Entry state registers.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          valid_q <= '0;
          rd_q    <= '0;
        end else begin
          valid_q <= valid_d;
          rd_q    <= rd_d;
        end
      end

      // Compare both sources against every valid entry.
      always_comb begin
        match1_s = 1'b0;
        match2_s = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
          if (valid_q[k] && (rd_q[k] == rs1_addr_i)) begin
            match1_s = 1'b1;
          end else begin
            match1_s = match1_s;
          end
          if (valid_q[k] && (rd_q[k] == rs2_addr_i)) begin
            match2_s = 1'b1;
          end else begin
            match2_s = match2_s;
          end
        end
      end

      assign hit1_o = match1_s && rs1_use_i && (rs1_addr_i != {ADDR_W{1'b0}});
      assign hit2_o = match2_s && rs2_use_i && (rs2_addr_i != {ADDR_W{1'b0}});
    end
  endgenerate

endmodule

// File: rtl/hazard_unit_v2.sv
// Load-use hazard controller: EX compare, scoreboard of older loads,
// freeze/stall/flush priority mux and a saturating stall-cycle counter.
module hazard_unit_v2
  import hazard_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] RS1addr_i,
  input  logic [ADDR_W-1:0] RS2addr_i,
  input  logic              RS1use_i,
  input  logic              RS2use_i,
  input  logic              MemRead_i,
  input  logic [ADDR_W-1:0] RdAddr_i,
  input  logic              MemBusy_i,
  input  logic              BranchTaken_i,
  output logic              PCWrite_o,
  output logic              Stall_o,
  output logic              NoOp_o,
  output logic              Flush_o,
  output logic              Freeze_o,
  output logic [1:0]        Cause_o,
  output logic [CNT_W-1:0]  StallCnt_o
);

  localparam int SB_DEPTH = (LOAD_LAT > 1) ? (LOAD_LAT - 1) : 0;

  logic             sb_hit1_s, sb_hit2_s;
  logic             ex_hit1_s, ex_hit2_s;
  logic             hazard_s;
  logic             push_valid_s;
  ctrl_t            ctrl_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign push_valid_s = MemRead_i && (RdAddr_i != {ADDR_W{1'b0}});

  load_scoreboard #(
    .ADDR_W (ADDR_W),
    .DEPTH  (SB_DEPTH)
  ) u_sb (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .advance_i    (!MemBusy_i),
    .push_valid_i (push_valid_s),
    .push_rd_i    (RdAddr_i),
    .rs1_addr_i   (RS1addr_i),
    .rs2_addr_i   (RS2addr_i),
    .rs1_use_i    (RS1use_i),
    .rs2_use_i    (RS2use_i),
    .hit1_o       (sb_hit1_s),
    .hit2_o       (sb_hit2_s)
  );

  assign ex_hit1_s = src_qualified(RS1use_i, RS1addr_i) && MemRead_i && (RdAddr_i == RS1addr_i);
  assign ex_hit2_s = src_qualified(RS2use_i, RS2addr_i) && MemRead_i && (RdAddr_i == RS2addr_i);
  assign hazard_s  = ex_hit1_s || ex_hit2_s || sb_hit1_s || sb_hit2_s;

  // Output priority: reset, freeze, load-use (beats a dependent branch), flush.
  always_comb begin
    ctrl_s = CTRL_IDLE;
    if (rst_i) begin
      ctrl_s = CTRL_IDLE;
    end else if (MemBusy_i) begin
      ctrl_s = CTRL_FREEZE;
    end else if (hazard_s) begin
      ctrl_s = CTRL_LOADUSE;
    end else if (BranchTaken_i) begin
      ctrl_s = CTRL_FLUSH;
    end else begin
      ctrl_s = CTRL_IDLE;
    end
  end

  // Saturating count of load-use bubble cycles.
  always_comb begin
    cnt_d = cnt_q;
    if ((ctrl_s.cause == CAUSE_LOADUSE) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign PCWrite_o  = ctrl_s.pc_write;
  assign Stall_o    = ctrl_s.stall;
  assign NoOp_o     = ctrl_s.noop;
  assign Flush_o    = ctrl_s.flush;
  assign Freeze_o   = ctrl_s.freeze;
  assign Cause_o    = ctrl_s.cause;
  assign StallCnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_unit_v2.sv
// Scoreboard bench for hazard_unit_v2 (LOAD_LAT=2, CNT_W=4): directed vectors
// push expected outputs, a negedge monitor pops and compares.
module tb_hazard_unit_v2;

  localparam logic [6:0] IDLE = 7'b1000000;
  localparam logic [6:0] LU   = 7'b0110001;
  localparam logic [6:0] FZ   = 7'b0100110;
  localparam logic [6:0] FL   = 7'b1001011;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mr, busy, br;
  logic       pcw, stl, nop, fls, frz;
  logic [1:0] cause;
  logic [3:0] cnt;

  typedef struct {
    logic [6:0] ctrl;
    logic [3:0] cnt;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hazard_unit_v2 #(.ADDR_W(5), .LOAD_LAT(2), .CNT_W(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .RS1addr_i     (rs1),
    .RS2addr_i     (rs2),
    .RS1use_i      (u1),
    .RS2use_i      (u2),
    .MemRead_i     (mr),
    .RdAddr_i      (rd),
    .MemBusy_i     (busy),
    .BranchTaken_i (br),
    .PCWrite_o     (pcw),
    .Stall_o       (stl),
    .NoOp_o        (nop),
    .Flush_o       (fls),
    .Freeze_o      (frz),
    .Cause_o       (cause),
    .StallCnt_o    (cnt)
  );

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (({pcw, stl, nop, fls, frz, cause} !== e.ctrl) || (cnt !== e.cnt)) begin
        n_err++;
        $display("FAIL %s: got ctrl=%b cnt=%0d, want ctrl=%b cnt=%0d",
                 e.name, {pcw, stl, nop, fls, frz, cause}, cnt, e.ctrl, e.cnt);
      end
    end
  end

  task automatic step(input logic r, input logic [4:0] a1, input logic s1,
                      input logic [4:0] a2, input logic s2,
                      input logic m, input logic [4:0] d, input logic b, input logic t,
                      input logic chk, input logic [6:0] ec, input logic [3:0] ecnt,
                      input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; rs1 = a1; u1 = s1; rs2 = a2; u2 = s2;
    mr = m; rd = d; busy = b; br = t;
    if (chk) begin
      x.ctrl = ec; x.cnt = ecnt; x.name = nm;
      exp_q.push_back(x);
    end
  endtask

  initial begin
    rst = 1'b1; rs1 = 5'd0; rs2 = 5'd0; u1 = 1'b0; u2 = 1'b0;
    mr = 1'b0; rd = 5'd0; busy = 1'b0; br = 1'b0;

    //    rst   rs1  u1    rs2  u2    mr    rd    busy  br    chk   exp   cnt
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE, 4'd0, "rst0");
    step(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, IDLE, 4'd0, "rst_idle");

    // Load-use stall, exactly two bubbles.
    step(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, LU,   4'd0, "lu_c0");
    step(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, LU,   4'd1, "lu_c1");
    step(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, IDLE, 4'd2, "lu_rel");

    // x0 destination and cleared use bit never stall.
    step(1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, IDLE, 4'd2, "x0_ex");
    step(1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, IDLE, 4'd2, "nouse_ex");
    step(1'b0, 5'd7, 1'b0, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, IDLE, 4'd2, "nouse_sb");
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, IDLE, 4'd2, "gap");

    // Freeze during stall: scoreboard holds, stall extends 1:1.
    step(1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, LU,   4'd2, "fz_lu0");
    step(1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, FZ,   4'd3, "fz_1");
    step(1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, FZ,   4'd3, "fz_2");
    step(1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, FZ,   4'd3, "fz_3");
    step(1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, LU,   4'd3, "fz_lu1");
    step(1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, IDLE, 4'd4, "fz_rel");

    // Branch alone flushes; a branch depending on a load stalls instead.
    step(1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, FL,   4'd4, "br_flush");
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, IDLE, 4'd4, "br_after");
    step(1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b1, 1'b1, LU,   4'd4, "br_hz0");
    step(1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, LU,   4'd5, "br_hz1");
    step(1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, FL,   4'd6, "br_hz_fl");
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, IDLE, 4'd6, "br_idle");

    // Back-to-back loads tracked independently.
    step(1'b0, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0, 1'b1, IDLE, 4'd6, "b2b_0");
    step(1'b0, 5'd10, 1'b1, 5'd11, 1'b1, 1'b1, 5'd11, 1'b0, 1'b0, 1'b1, LU,  4'd6, "b2b_1");
    step(1'b0, 5'd10, 1'b1, 5'd11, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, LU,   4'd7, "b2b_2");
    step(1'b0, 5'd10, 1'b1, 5'd11, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, IDLE, 4'd8, "b2b_rel");

    // Reset mid-stall drops the pending entry and clears the counter.
    step(1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, LU,   4'd8, "rs_lu");
    step(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, IDLE, 4'd9, "rs_mid");
    step(1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, IDLE, 4'd0, "rs_after");

    // Counter saturates at 15.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 5'd12, 1'b1, 5'd0, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0, 1'b1, LU,
           (i >= 15) ? 4'd15 : 4'(i), "sat");
    end
    step(1'b0, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, LU,   4'd15, "sat_sb");
    step(1'b0, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, IDLE, 4'd15, "sat_rel");

    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_unit_v2.md
# hazard_unit_v2

Parametrised load-use hazard controller for the 5-stage RISC-V pipeline, sitting between the ID stage and the pipeline-register enables. It supports data memories with a load latency of one or more cycles and tracks in-flight loads beyond EX in a small scoreboard. It also handles whole-pipe freeze on a memory-busy handshake, IF/ID flush on taken branches, per-source use qualification, x0 suppression, and a saturating stall-cycle counter.

## Interface
Parameters:
- ADDR_W, 5, register address width
- LOAD_LAT, 2, bubbles needed between a load in EX and a dependent instruction in ID; minimum 1
- CNT_W, 32, stall counter width

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; synchronous, active-high
- RS1addr_i  in  ADDR_W  rs1 of the instruction in ID
- RS2addr_i  in  ADDR_W  rs2 of the instruction in ID
- RS1use_i  in  1  ID instruction reads rs1
- RS2use_i  in  1  ID instruction reads rs2
- MemRead_i  in  1  the instruction in EX (ID/EX register) is a load
- RdAddr_i  in  ADDR_W  rd of the instruction in EX
- MemBusy_i  in  1  data memory not ready; the pipe must freeze
- BranchTaken_i  in  1  branch resolved taken in ID
- PCWrite_o  out  1  PC enable
- Stall_o  out  1  hold IF/ID
- NoOp_o  out  1  insert a bubble into ID/EX
- Flush_o  out  1  zero IF/ID
- Freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB
- Cause_o  out  2  current action cause
- StallCnt_o  out  CNT_W  count of load-use stall cycles

## Operation
Scoreboard:
- Holds LOAD_LAT-1 entries {valid, rd}. Entry k represents the load k+1 stages past EX. When LOAD_LAT=1 there are no entries.
- When the pipe is advancing (MemBusy_i=0):
  - entry 0 <= {MemRead_i && RdAddr_i!=0, RdAddr_i}
  - entry k <= entry k-1
- When MemBusy_i=1, all entries hold.

Match:
- src_hit(s) = use_s && addr_s!=0 && addr_s equals either (a) RdAddr_i with MemRead_i=1, or (b) any valid entry's rd.
- hazard = src_hit(rs1) || src_hit(rs2).

Output priority, evaluated combinationally each cycle:
1. rst_i=1: idle outputs (PCWrite_o=1, all other 1-bit outputs 0, Cause_o=NONE).
2. MemBusy_i=1: Freeze_o=1, PCWrite_o=0, Stall_o=1, NoOp_o=0, Flush_o=0, Cause_o=FREEZE.
3. hazard: PCWrite_o=0, Stall_o=1, NoOp_o=1, Flush_o=0, Cause_o=LOADUSE. A concurrent BranchTaken_i is ignored, because the branch depends on the load.
4. BranchTaken_i: Flush_o=1, PCWrite_o=1, Stall_o=0, NoOp_o=0, Cause_o=FLUSH.
5. Otherwise: idle outputs.

StallCnt_o:
- Increments by 1 on every cycle where Cause_o=LOADUSE.
- Saturates at all-ones.
- Freeze cycles are not counted.

## Timing
- All control outputs are combinational from the current inputs and scoreboard state, with zero-cycle latency.
- The scoreboard and counter update at the rising edge.
- On reset, at the first edge with rst_i=1: all entries are invalidated and StallCnt_o=0. Outputs are idle while rst_i is high.
- A reset asserted mid-stall drops all pending hazards. The first cycle after reset shows no stall unless EX presents a load.
- A dependent instruction stalls exactly LOAD_LAT cycles when there is no freeze. Freeze cycles extend the stall 1:1 because the scoreboard holds.
- A bubble in EX (MemRead_i=0) pushes an invalid entry.
- Back-to-back loads are each tracked independently.
- A load with rd=x0 never causes a stall.
- A source with its use bit clear never stalls, even when its address matches.

## Structure
- Package hazard_pkg holds:
  - REG_ADDR_W=5
  - Cause_o encoding: NONE=0, LOADUSE=1, FREEZE=2, FLUSH=3
  - idle output constants
- Sub-module load_scoreboard holds the shift register and produces hit1/hit2 from the rs addresses and use bits.
  - Its shift-register depth is LOAD_LAT-1.
  - When LOAD_LAT=1 it is generated away and its hits are tied to 0.
- The top level holds the EX compare, the priority mux and the counter.

## Test plan
- Load-use stall, LOAD_LAT=2: lw x5 in EX; next ID has rs1=x5, RS1use_i=1. Required: NoOp_o=1 and PCWrite_o=0 for exactly 2 cycles, then release; StallCnt_o=2.
- x0 and use suppression: lw x0 in EX with rs1=0 -> no stall. lw x7 in EX with RS2addr_i=7, RS2use_i=0 -> no stall.
- Freeze during stall: lw x3 in EX with a dependent in ID; MemBusy_i=1 for 3 cycles starting at stall cycle 1. Required: Cause_o=FREEZE for 3 cycles, then 1 more LOADUSE cycle; total StallCnt_o=2.
- Branch vs hazard: BranchTaken_i=1 with no hazard -> Flush_o=1 for 1 cycle. BranchTaken_i=1 with rs1 matching a load in EX -> Flush_o=0 and NoOp_o=1.
- Reset mid-stall: assert rst_i during stall cycle 1 of lw x9. Required: idle outputs, StallCnt_o=0, and no stall after release with MemRead_i=0.
- Counter saturation, CNT_W=4: hold a hazard for 20 cycles. Required: StallCnt_o stops at 15.
